// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decode (ID) stage: opcode encoding,
// control vector bit positions and the opcode-to-control decode function.
// Imported by decode_stage.
// -----------------------------------------------------------------------------
package decode_pkg;

  // Control vector width, fixed by the encoding below.
  localparam int CTRL_W = 11;

  // Bit positions inside the control vector.
  localparam int CTRL_ALUOP  = 0;
  localparam int CTRL_ALUSRC = 1;
  localparam int CTRL_MEMW   = 2;
  localparam int CTRL_MEMR   = 3;
  localparam int CTRL_MTR    = 4;
  localparam int CTRL_BRANCH = 5;
  localparam int CTRL_REGW   = 6;
  localparam int CTRL_IN     = 7;
  localparam int CTRL_OUT    = 8;
  localparam int CTRL_STACK  = 9;
  localparam int CTRL_PUSH   = 10;

  // Major opcode, three bits wide.
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ALU  = 3'b001,
    OP_ALUI = 3'b010,
    OP_LDD  = 3'b011,
    OP_STD  = 3'b100,
    OP_BR   = 3'b101,
    OP_PORT = 3'b110,
    OP_STK  = 3'b111
  } opcodeT;

  // Maps {op, sub} to the control vector. The sub bit only matters for the
  // port and stack opcodes, where it picks the direction (in/out, pop/push).
  function automatic logic [CTRL_W-1:0] decodeCtrl(input opcodeT op, input logic sub);
    logic [CTRL_W-1:0] ctrl;
    ctrl = '0;
    case (op)
      OP_NOP: ctrl = '0;
      OP_ALU: begin
        ctrl[CTRL_ALUOP] = 1'b1;
        ctrl[CTRL_REGW]  = 1'b1;
      end
      OP_ALUI: begin
        ctrl[CTRL_ALUOP]  = 1'b1;
        ctrl[CTRL_ALUSRC] = 1'b1;
        ctrl[CTRL_REGW]   = 1'b1;
      end
      OP_LDD: begin
        ctrl[CTRL_ALUSRC] = 1'b1;
        ctrl[CTRL_MEMR]   = 1'b1;
        ctrl[CTRL_MTR]    = 1'b1;
        ctrl[CTRL_REGW]   = 1'b1;
      end
      OP_STD: begin
        ctrl[CTRL_ALUSRC] = 1'b1;
        ctrl[CTRL_MEMW]   = 1'b1;
      end
      OP_BR: ctrl[CTRL_BRANCH] = 1'b1;
      OP_PORT: begin
        if (sub) begin
          ctrl[CTRL_OUT] = 1'b1;
        end else begin
          ctrl[CTRL_IN]   = 1'b1;
          ctrl[CTRL_REGW] = 1'b1;
        end
      end
      OP_STK: begin
        ctrl[CTRL_STACK] = 1'b1;
        if (sub) begin
          ctrl[CTRL_PUSH] = 1'b1;
          ctrl[CTRL_MEMW] = 1'b1;
        end else begin
          ctrl[CTRL_MEMR] = 1'b1;
          ctrl[CTRL_MTR]  = 1'b1;
          ctrl[CTRL_REGW] = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// decode_regfile
// General purpose register file for the decode stage: 2**ADDR_W entries of
// DATA_W bits, one synchronous write port, two combinational read ports,
// all entries cleared by the asynchronous active-low reset.
//
// Optional feature (macro DECODE_WB_BYPASS_EN):
//   defined   - a read of the address being written this cycle returns the
//               write data (write-through), independently on each read port.
//   undefined - reads return the value stored before the write.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_wrEn     in   write enable
//   i_wrAddr   in   write address
//   i_wrData   in   write data
//   i_rdAddrA  in   read port A address
//   o_rdDataA  out  read port A data
//   i_rdAddrB  in   read port B address
//   o_rdDataB  out  read port B data
// -----------------------------------------------------------------------------
module decode_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddrA,
  output logic [DATA_W-1:0] o_rdDataA,
  input  logic [ADDR_W-1:0] i_rdAddrB,
  output logic [DATA_W-1:0] o_rdDataB
);

  localparam int REG_CNT = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [REG_CNT];

  // Storage array. Every entry returns to zero on reset; afterwards a single
  // entry is updated per cycle from the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_regs[i_wrAddr] <= i_wrData;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // Write-through reads: a same-cycle writeback to the addressed register
  // wins over the stored value, so the writeback stage need not run ahead.
  always_comb begin
    o_rdDataA = r_regs[i_rdAddrA];
    o_rdDataB = r_regs[i_rdAddrB];
    if (i_wrEn && (i_wrAddr == i_rdAddrA)) begin
      o_rdDataA = i_wrData;
    end
    if (i_wrEn && (i_wrAddr == i_rdAddrB)) begin
      o_rdDataB = i_wrData;
    end
  end
`else
  // Plain reads of the stored value; a write in this cycle becomes visible
  // on the following cycle.
  always_comb begin
    o_rdDataA = r_regs[i_rdAddrA];
    o_rdDataB = r_regs[i_rdAddrB];
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Parametrised instruction decode (ID) stage sitting between fetch and
// execute. Extracts the register/opcode/immediate fields, decodes the opcode
// into a control vector, reads two operands from the register file (which
// also takes the writeback port) and detects load-use hazards against the
// instruction currently held in the ID/EX register. The ID/EX register is
// the stage output, with a valid/ready handshake, flush and a saturating
// count of stall cycles.
//
// Instruction layout (low bits first):
//   [3]                   sub
//   [4 +: ADDR_W]         rd
//   [4+ADDR_W +: ADDR_W]  rs2
//   [4+2*ADDR_W +: ADDR_W] rs1
//   [4+3*ADDR_W +: 3]     op
//   [INSTR_W-1 -: DATA_W] immediate
// The layout requires 3*ADDR_W+7 <= INSTR_W-DATA_W.
//
// Optional feature: define DECODE_WB_BYPASS_EN for write-through register
// reads (see decode_regfile).
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   i_inValid       in   fetch presents an instruction
//   i_inInstr       in   instruction word
//   o_inReady       out  instruction accepted this cycle
//   i_flush         in   kill the ID/EX contents (taken branch)
//   i_wbEn          in   writeback enable
//   i_wbAddr        in   writeback register
//   i_wbData        in   writeback data
//   o_outValid      out  ID/EX holds a valid instruction
//   i_outReady      in   execute consumes ID/EX
//   o_outCtrl       out  control vector
//   o_outRs1Data    out  operand 1
//   o_outRs2Data    out  operand 2
//   o_outRd         out  destination register
//   o_outImm        out  immediate
//   o_stallCnt      out  saturating count of stall cycles
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inValid,
  input  logic [INSTR_W-1:0] i_inInstr,
  output logic               o_inReady,
  input  logic               i_flush,
  input  logic               i_wbEn,
  input  logic [ADDR_W-1:0]  i_wbAddr,
  input  logic [DATA_W-1:0]  i_wbData,
  output logic               o_outValid,
  input  logic               i_outReady,
  output logic [CTRL_W-1:0]  o_outCtrl,
  output logic [DATA_W-1:0]  o_outRs1Data,
  output logic [DATA_W-1:0]  o_outRs2Data,
  output logic [ADDR_W-1:0]  o_outRd,
  output logic [DATA_W-1:0]  o_outImm,
  output logic [15:0]        o_stallCnt
);

  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [2:0]        w_op;
  logic              w_sub;
  logic [DATA_W-1:0] w_imm;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_rs1Data;
  logic [DATA_W-1:0] w_rs2Data;
  logic              w_hz;
  logic              w_ld;
  logic              w_inReady;
  logic              w_unusedInstr;

  logic              r_outValid;
  logic [CTRL_W-1:0] r_outCtrl;
  logic [DATA_W-1:0] r_outRs1Data;
  logic [DATA_W-1:0] r_outRs2Data;
  logic [ADDR_W-1:0] r_outRd;
  logic [DATA_W-1:0] r_outImm;
  logic [15:0]       r_stallCnt;

  // Field extraction and opcode decode. Low instruction bits and any gap
  // between the opcode and the immediate carry no meaning for this stage.
  always_comb begin
    w_rd   = i_inInstr[4 +: ADDR_W];
    w_rs2  = i_inInstr[4 + ADDR_W +: ADDR_W];
    w_rs1  = i_inInstr[4 + 2 * ADDR_W +: ADDR_W];
    w_op   = i_inInstr[4 + 3 * ADDR_W +: 3];
    w_sub  = i_inInstr[3];
    w_imm  = i_inInstr[INSTR_W-1 -: DATA_W];
    w_ctrl = decodeCtrl(opcodeT'(w_op), w_sub);
  end

  assign w_unusedInstr = ^i_inInstr;

  decode_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wrEn    (i_wbEn),
    .i_wrAddr  (i_wbAddr),
    .i_wrData  (i_wbData),
    .i_rdAddrA (w_rs1),
    .o_rdDataA (w_rs1Data),
    .i_rdAddrB (w_rs2),
    .o_rdDataB (w_rs2Data)
  );

  // Load-use hazard: the load sitting in ID/EX has not produced its data yet,
  // so a dependent instruction must wait one cycle. Both source fields are
  // checked even when the opcode ignores one of them, which keeps the check
  // independent of the decode. The ID/EX register may load whenever it is
  // empty or being drained by execute.
  always_comb begin
    w_hz = i_inValid && r_outValid && r_outCtrl[CTRL_MEMR] &&
           ((r_outRd == w_rs1) || (r_outRd == w_rs2));
    w_ld = !r_outValid || i_outReady;
    w_inReady = w_ld && !w_hz && !i_flush;
  end

  // ID/EX pipeline register. Flush only drops valid; a hazard inserts a
  // bubble with a cleared control vector so that the load no longer matches
  // next cycle and the dependent instruction goes through after exactly one
  // bubble. When execute is stalled the contents are held unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_outCtrl    <= '0;
      r_outRs1Data <= '0;
      r_outRs2Data <= '0;
      r_outRd      <= '0;
      r_outImm     <= '0;
    end else if (i_flush) begin
      r_outValid <= 1'b0;
    end else if (w_ld && w_hz) begin
      r_outValid <= 1'b0;
      r_outCtrl  <= '0;
    end else if (w_ld && i_inValid) begin
      r_outValid   <= 1'b1;
      r_outCtrl    <= w_ctrl;
      r_outRs1Data <= w_rs1Data;
      r_outRs2Data <= w_rs2Data;
      r_outRd      <= w_rd;
      r_outImm     <= w_imm;
    end else if (w_ld) begin
      r_outValid <= 1'b0;
    end
  end

  // Counts every cycle in which fetch offers an instruction that is not
  // taken, whatever the reason (hazard, back-pressure or flush). Sticks at
  // all ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (i_inValid && !w_inReady && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign o_inReady    = w_inReady;
  assign o_outValid   = r_outValid;
  assign o_outCtrl    = r_outCtrl;
  assign o_outRs1Data = r_outRs1Data;
  assign o_outRs2Data = r_outRs2Data;
  assign o_outRd      = r_outRd;
  assign o_outImm     = r_outImm;
  assign o_stallCnt   = r_stallCnt;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage with default parameters. Directed
// scenarios use hand-derived constants; the random scenario is checked
// against a cycle-level reference model of the stage's rules.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 32;
  localparam int CTRL_W  = 11;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               inValid;
  logic [INSTR_W-1:0] inInstr;
  logic               inReady;
  logic               flush;
  logic               wbEn;
  logic [ADDR_W-1:0]  wbAddr;
  logic [DATA_W-1:0]  wbData;
  logic               outValid;
  logic               outReady;
  logic [CTRL_W-1:0]  outCtrl;
  logic [DATA_W-1:0]  outRs1Data;
  logic [DATA_W-1:0]  outRs2Data;
  logic [ADDR_W-1:0]  outRd;
  logic [DATA_W-1:0]  outImm;
  logic [15:0]        stallCnt;

  int testsRun;
  int testsFailed;

  // Reference model state for the random scenario.
  logic              mValid;
  logic [CTRL_W-1:0] mCtrl;
  logic [DATA_W-1:0] mRs1;
  logic [DATA_W-1:0] mRs2;
  logic [ADDR_W-1:0] mRd;
  logic [DATA_W-1:0] mImm;
  logic [15:0]       mStall;
  logic [DATA_W-1:0] mRegs [8];

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inValid    (inValid),
    .i_inInstr    (inInstr),
    .o_inReady    (inReady),
    .i_flush      (flush),
    .i_wbEn       (wbEn),
    .i_wbAddr     (wbAddr),
    .i_wbData     (wbData),
    .o_outValid   (outValid),
    .i_outReady   (outReady),
    .o_outCtrl    (outCtrl),
    .o_outRs1Data (outRs1Data),
    .o_outRs2Data (outRs2Data),
    .o_outRd      (outRd),
    .o_outImm     (outImm),
    .o_stallCnt   (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mkInstr(input logic [2:0] op, input logic [2:0] rs1,
                                          input logic [2:0] rs2, input logic [2:0] rd,
                                          input logic sub, input logic [15:0] imm);
    logic [31:0] v;
    v = '0;
    v[31:16] = imm;
    v[15:13] = op;
    v[12:10] = rs1;
    v[9:7]   = rs2;
    v[6:4]   = rd;
    v[3]     = sub;
    return v;
  endfunction

  // Expected control vector straight from the opcode table, as hex words.
  function automatic logic [10:0] expCtrl(input logic [2:0] op, input logic sub);
    case (op)
      3'd0: return 11'h000;
      3'd1: return 11'h041;
      3'd2: return 11'h043;
      3'd3: return 11'h05A;
      3'd4: return 11'h006;
      3'd5: return 11'h020;
      3'd6: return sub ? 11'h100 : 11'h0C0;
      default: return sub ? 11'h604 : 11'h258;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inValid  = 1'b0;
    inInstr  = '0;
    flush    = 1'b0;
    wbEn     = 1'b0;
    wbAddr   = '0;
    wbData   = '0;
    outReady = 1'b1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    idleInputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({outValid, outCtrl, outRs1Data, outRs2Data, outRd, outImm, stallCnt} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got valid=%0b ctrl=%h rs1=%h rs2=%h rd=%0d imm=%h stall=%0d, want all zero",
               outValid, outCtrl, outRs1Data, outRs2Data, outRd, outImm, stallCnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    testsRun++;
    if (inReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", inReady);
    end
  endtask

  task automatic test_alu_reg();
    doReset();
    wbEn = 1'b1; wbAddr = 3'd3; wbData = 16'h00A5;
    tick();
    wbEn = 1'b0;
    inValid = 1'b1;
    inInstr = mkInstr(3'd1, 3'd3, 3'd0, 3'd5, 1'b0, 16'h0042);
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outValid !== 1'b1 || outCtrl !== 11'h041) begin
      testsFailed++;
      $display("[TB] FAIL alu_reg_ctrl: got valid=%b ctrl=%h want valid=1 ctrl=041", outValid, outCtrl);
    end
    testsRun++;
    if (outRs1Data !== 16'h00A5 || outRs2Data !== 16'h0000 || outRd !== 3'd5 || outImm !== 16'h0042) begin
      testsFailed++;
      $display("[TB] FAIL alu_reg_data: got rs1=%h rs2=%h rd=%0d imm=%h want 00a5 0000 5 0042",
               outRs1Data, outRs2Data, outRd, outImm);
    end
    tick();
    testsRun++;
    if (outValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL alu_reg_drain: got valid=%b want 0", outValid);
    end
  endtask

  task automatic test_load_use();
    doReset();
    inValid = 1'b1;
    inInstr = mkInstr(3'd3, 3'd0, 3'd0, 3'd2, 1'b0, 16'h0010);
    tick();
    testsRun++;
    if (outValid !== 1'b1 || outCtrl !== 11'h05A || outRd !== 3'd2) begin
      testsFailed++;
      $display("[TB] FAIL load_capture: got valid=%b ctrl=%h rd=%0d want 1 05a 2", outValid, outCtrl, outRd);
    end
    inInstr = mkInstr(3'd1, 3'd2, 3'd0, 3'd1, 1'b0, 16'h0000);
    #1;
    testsRun++;
    if (inReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL load_use_ready: got %b want 0", inReady);
    end
    tick();
    testsRun++;
    if (outValid !== 1'b0 || outCtrl !== 11'h000 || stallCnt !== 16'd1 || inReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL load_use_bubble: got valid=%b ctrl=%h stall=%0d ready=%b want 0 000 1 1",
               outValid, outCtrl, stallCnt, inReady);
    end
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outValid !== 1'b1 || outCtrl !== 11'h041 || outRd !== 3'd1 || stallCnt !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL load_use_accept: got valid=%b ctrl=%h rd=%0d stall=%0d want 1 041 1 1",
               outValid, outCtrl, outRd, stallCnt);
    end
  endtask

  task automatic test_back_pressure();
    doReset();
    inValid = 1'b1;
    inInstr = mkInstr(3'd2, 3'd0, 3'd0, 3'd1, 1'b0, 16'h1111);
    tick();
    outReady = 1'b0;
    inInstr = mkInstr(3'd5, 3'd1, 3'd1, 3'd6, 1'b0, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      #1;
      testsRun++;
      if (inReady !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hold_ready cycle %0d: got %b want 0", i, inReady);
      end
      tick();
      testsRun++;
      if (outValid !== 1'b1 || outCtrl !== 11'h043 || outRd !== 3'd1 || outImm !== 16'h1111) begin
        testsFailed++;
        $display("[TB] FAIL hold_outputs cycle %0d: got valid=%b ctrl=%h rd=%0d imm=%h want 1 043 1 1111",
                 i, outValid, outCtrl, outRd, outImm);
      end
    end
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outValid !== 1'b1 || outCtrl !== 11'h020 || outRd !== 3'd6 || outImm !== 16'h2222 || stallCnt !== 16'd3) begin
      testsFailed++;
      $display("[TB] FAIL hold_resume: got valid=%b ctrl=%h rd=%0d imm=%h stall=%0d want 1 020 6 2222 3",
               outValid, outCtrl, outRd, outImm, stallCnt);
    end
  endtask

  task automatic test_flush_wb();
    doReset();
    inValid = 1'b1;
    inInstr = mkInstr(3'd4, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0004);
    tick();
    testsRun++;
    if (outValid !== 1'b1 || outCtrl !== 11'h006) begin
      testsFailed++;
      $display("[TB] FAIL flush_std_capture: got valid=%b ctrl=%h want 1 006", outValid, outCtrl);
    end
    inValid = 1'b0;
    flush = 1'b1;
    wbEn = 1'b1; wbAddr = 3'd7; wbData = 16'hBEEF;
    tick();
    flush = 1'b0;
    wbEn = 1'b0;
    testsRun++;
    if (outValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_valid: got %b want 0", outValid);
    end
    inValid = 1'b1;
    inInstr = mkInstr(3'd1, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000);
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outRs1Data !== 16'hBEEF || outRs2Data !== 16'hBEEF) begin
      testsFailed++;
      $display("[TB] FAIL flush_wb_lands: got rs1=%h rs2=%h want beef beef", outRs1Data, outRs2Data);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] want;
    doReset();
    want = BYPASS ? 16'h1234 : 16'h0000;
    inValid = 1'b1;
    inInstr = mkInstr(3'd1, 3'd0, 3'd4, 3'd1, 1'b0, 16'h0000);
    wbEn = 1'b1; wbAddr = 3'd4; wbData = 16'h1234;
    tick();
    wbEn = 1'b0;
    testsRun++;
    if (outRs2Data !== want || outRs1Data !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL bypass_read: got rs1=%h rs2=%h want 0000 %h", outRs1Data, outRs2Data, want);
    end
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outRs2Data !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL bypass_later_read: got %h want 1234", outRs2Data);
    end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    wbEn = 1'b1; wbAddr = 3'd2; wbData = 16'h5555;
    tick();
    wbEn = 1'b0;
    inValid = 1'b1;
    inInstr = mkInstr(3'd3, 3'd0, 3'd0, 3'd2, 1'b0, 16'h0000);
    tick();
    inInstr = mkInstr(3'd1, 3'd2, 3'd2, 3'd3, 1'b0, 16'h0000);
    #1;
    testsRun++;
    if (inReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midstall_ready: got %b want 0", inReady);
    end
    #1;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({outValid, outCtrl, outRs1Data, outRs2Data, outRd, outImm, stallCnt} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midstall_async_clear: got valid=%b ctrl=%h rs1=%h rs2=%h rd=%0d imm=%h stall=%0d want all zero",
               outValid, outCtrl, outRs1Data, outRs2Data, outRd, outImm, stallCnt);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    testsRun++;
    if (inReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midstall_release_ready: got %b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    testsRun++;
    if (outValid !== 1'b1 || outRs1Data !== 16'h0000 || outRs2Data !== 16'h0000 || stallCnt !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL midstall_regs_cleared: got valid=%b rs1=%h rs2=%h stall=%0d want 1 0000 0000 0",
               outValid, outRs1Data, outRs2Data, stallCnt);
    end
  endtask

  task automatic test_random();
    logic [2:0]  rs1F, rs2F, rdF, opF;
    logic        subF, hz, ld, expReady;
    logic [15:0] rd1, rd2;
    doReset();
    mValid = 1'b0; mCtrl = '0; mRs1 = '0; mRs2 = '0; mRd = '0; mImm = '0; mStall = '0;
    for (int r = 0; r < 8; r++) mRegs[r] = '0;
    for (int c = 0; c < 400; c++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      inInstr  = $urandom;
      outReady = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 9) == 0);
      wbEn     = ($urandom_range(0, 9) < 4);
      wbAddr   = 3'($urandom_range(0, 7));
      wbData   = 16'($urandom);
      #1;
      rs1F = inInstr[12:10];
      rs2F = inInstr[9:7];
      rdF  = inInstr[6:4];
      opF  = inInstr[15:13];
      subF = inInstr[3];
      hz = inValid && mValid && (mCtrl[3] == 1'b1) && (mRd == rs1F || mRd == rs2F);
      ld = !mValid || outReady;
      expReady = ld && !hz && !flush;
      testsRun++;
      if (inReady !== expReady) begin
        testsFailed++;
        $display("[TB] FAIL rand_in_ready cycle %0d: got %b want %b", c, inReady, expReady);
      end
      rd1 = (BYPASS && wbEn && wbAddr == rs1F) ? wbData : mRegs[rs1F];
      rd2 = (BYPASS && wbEn && wbAddr == rs2F) ? wbData : mRegs[rs2F];
      if (inValid && !expReady && mStall != 16'hFFFF) mStall = mStall + 16'd1;
      if (flush) begin
        mValid = 1'b0;
      end else if (ld && hz) begin
        mValid = 1'b0;
        mCtrl  = '0;
      end else if (ld && inValid) begin
        mValid = 1'b1;
        mCtrl  = expCtrl(opF, subF);
        mRs1   = rd1;
        mRs2   = rd2;
        mRd    = rdF;
        mImm   = inInstr[31:16];
      end else if (ld) begin
        mValid = 1'b0;
      end
      if (wbEn) mRegs[wbAddr] = wbData;
      @(posedge clk);
      #1;
      testsRun++;
      if (outValid !== mValid || outCtrl !== mCtrl || outRd !== mRd || outImm !== mImm) begin
        testsFailed++;
        $display("[TB] FAIL rand_ctrl cycle %0d: got valid=%b ctrl=%h rd=%0d imm=%h want %b %h %0d %h",
                 c, outValid, outCtrl, outRd, outImm, mValid, mCtrl, mRd, mImm);
      end
      testsRun++;
      if (outRs1Data !== mRs1 || outRs2Data !== mRs2) begin
        testsFailed++;
        $display("[TB] FAIL rand_operands cycle %0d: got rs1=%h rs2=%h want %h %h",
                 c, outRs1Data, outRs2Data, mRs1, mRs2);
      end
      testsRun++;
      if (stallCnt !== mStall) begin
        testsFailed++;
        $display("[TB] FAIL rand_stall_cnt cycle %0d: got %0d want %0d", c, stallCnt, mStall);
      end
    end
    idleInputs();
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_alu_reg();
    test_load_use();
    test_back_pressure();
    test_flush_wb();
    test_bypass();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
